// File: rtl/data_sram_pkg.sv
// Shared constants and helpers for the data SRAM responder: confreg offsets,
// register reset values and the byte-lane merge used on every write path.
package data_sram_pkg;

   localparam logic [15:0] CFG_LED     = 16'h0000;
   localparam logic [15:0] CFG_TIMER   = 16'h0004;
   localparam logic [15:0] CFG_COMPARE = 16'h0008;
   localparam logic [15:0] CFG_SCRATCH = 16'h000C;

   localparam logic [15:0] LED_RST     = 16'h0000;
   localparam logic [31:0] TIMER_RST   = 32'h0000_0000;
   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
   localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;

   // Lanes with wen[i]=1 take the new byte, the rest keep the old one.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  wen);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (wen[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running TIMER with COMPARE and a sticky match interrupt.
// Only built when CONFREG_TIMER_EN is defined.
module confreg_timer
   import data_sram_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        timer_wr_i,
   input  logic        compare_wr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] timer_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic [31:0] timer_q, timer_d;
   logic [31:0] compare_q, compare_d;
   logic        int_q, int_d;

   // wdata_i is already byte-merged with the register it targets.
   // A COMPARE write beats a same-cycle match, so the clear always wins.
   always_comb begin
      timer_d   = timer_wr_i ? wdata_i : timer_q + 32'd1;
      compare_d = compare_wr_i ? wdata_i : compare_q;
      int_d     = compare_wr_i ? 1'b0 : (int_q | (timer_q == compare_q));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         timer_q   <= TIMER_RST;
         compare_q <= COMPARE_RST;
         int_q     <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         compare_q <= compare_d;
         int_q     <= int_d;
      end
   end

   assign timer_o     = timer_q;
   assign compare_o   = compare_q;
   assign timer_int_o = int_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: word RAM plus a confreg window (LED, TIMER, COMPARE, SCRATCH).
// The timer block is optional and is built only when CONFREG_TIMER_EN is defined.
module data_sram_responder
   import data_sram_pkg::*;
#(
   parameter int          ADDR_W       = 12,
   parameter logic [31:0] CONFREG_BASE = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        timer_int
);

   // Protocol: data_sram_en qualifies one request per cycle and is always
   // accepted (no backpressure); read data is valid the cycle after a read.
   logic              cfg_sel;
   logic [15:0]       cfg_off;
   logic [ADDR_W-1:0] ram_idx;
   logic              rd_req, wr_req, cfg_wr, ram_wr;
   logic [31:0]       cfg_rdata, cfg_merged, timer_val, compare_val;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       scratch_q, scratch_d;
   logic [15:0]       led_q, led_d;
   logic [31:0]       ram_q [2**ADDR_W];
   logic [1:0]        unused_addr_lo;

   assign cfg_sel        = (data_sram_addr[31:16] == CONFREG_BASE[31:16]);
   assign cfg_off        = {data_sram_addr[15:2], 2'b00};
   assign ram_idx        = data_sram_addr[ADDR_W+1:2];
   assign rd_req         = rst && data_sram_en && (data_sram_wen == 4'h0);
   assign wr_req         = rst && data_sram_en && (data_sram_wen != 4'h0);
   assign cfg_wr         = wr_req && cfg_sel;
   assign ram_wr         = wr_req && !cfg_sel;
   assign unused_addr_lo = data_sram_addr[1:0];

`ifdef CONFREG_TIMER_EN
   logic timer_wr, compare_wr;

   assign timer_wr   = cfg_wr && (cfg_off == CFG_TIMER);
   assign compare_wr = cfg_wr && (cfg_off == CFG_COMPARE);

   confreg_timer u_timer (
      .clk_i        (clk),
      .rst_ni       (rst),
      .timer_wr_i   (timer_wr),
      .compare_wr_i (compare_wr),
      .wdata_i      (cfg_merged),
      .timer_o      (timer_val),
      .compare_o    (compare_val),
      .timer_int_o  (timer_int)
   );
`else
   assign timer_val   = 32'h0;
   assign compare_val = 32'h0;
   assign timer_int   = 1'b0;
`endif

   // The read mux doubles as the "old value" for byte-merged confreg writes.
   always_comb begin
      cfg_rdata = 32'h0;
      case (cfg_off)
         CFG_LED:     cfg_rdata = {16'h0, led_q};
         CFG_TIMER:   cfg_rdata = timer_val;
         CFG_COMPARE: cfg_rdata = compare_val;
         CFG_SCRATCH: cfg_rdata = scratch_q;
         default:     cfg_rdata = 32'h0;
      endcase
      cfg_merged = byte_merge(cfg_rdata, data_sram_wdata, data_sram_wen);
   end

   always_comb begin
      led_d     = led_q;
      scratch_d = scratch_q;
      rdata_d   = rdata_q;
      if (cfg_wr && (cfg_off == CFG_LED))     led_d     = cfg_merged[15:0];
      if (cfg_wr && (cfg_off == CFG_SCRATCH)) scratch_d = cfg_merged;
      if (rd_req) rdata_d = cfg_sel ? cfg_rdata : ram_q[ram_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q   <= 32'h0;
         led_q     <= LED_RST;
         scratch_q <= SCRATCH_RST;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         scratch_q <= scratch_d;
      end
   end

   // RAM contents survive reset; only the write strobe is gated by it.
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) ram_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led             = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder; timer expectations
// follow CONFREG_TIMER_EN when it is defined for the build.
module tb_data_sram_responder;

   logic        clk;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic        timer_int;

   data_sram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .timer_int       (timer_int)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ram_m [0:4095];
   logic [15:0] led_m;
   logic [31:0] scratch_m;
   logic [31:0] compare_m;
   logic [31:0] base_val;
   int          base_edge;
   logic        int_m;
   logic [31:0] rdata_m;
   logic [11:0] pool [16];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] w);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Timer value held right now: loaded value plus edges elapsed since the load.
   function automatic logic [31:0] timer_now();
      return base_val + 32'(cyc - base_edge);
   endfunction

   function automatic logic [31:0] cfg_read(input logic [15:0] off);
      logic [31:0] v;
      v = 32'h0;
      if (off == 16'h0000) v = {16'h0, led_m};
      if (off == 16'h000C) v = scratch_m;
`ifdef CONFREG_TIMER_EN
      if (off == 16'h0004) v = timer_now();
      if (off == 16'h0008) v = compare_m;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   logic resp_pend = 1'b0;
   always @(posedge clk) resp_pend <= rst && data_sram_en && (data_sram_wen == 4'h0);

   always @(negedge clk) begin
      if (resp_pend) begin
         if (exp_q.size() == 0) begin
            check("rdata_unexpected", data_sram_rdata, 32'hxxxx_xxxx);
         end else begin
            check("rdata", data_sram_rdata, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd);
      logic        cfg;
      logic [15:0] off;
      int          idx;
      logic [31:0] v;
      rst = 1'b1;
      data_sram_en = en;
      data_sram_wen = wen;
      data_sram_addr = addr;
      data_sram_wdata = wd;
      cfg = (addr[31:16] == 16'hBFAF);
      off = {addr[15:2], 2'b00};
      idx = int'(addr[13:2]);
`ifdef CONFREG_TIMER_EN
      if (en && wen != 4'h0 && cfg && off == 16'h0008) int_m = 1'b0;
      else if (timer_now() == compare_m) int_m = 1'b1;
`endif
      if (en && wen == 4'h0) begin
         v = cfg ? cfg_read(off) : ram_m[idx];
         exp_q.push_back(v);
         rdata_m = v;
      end else if (en) begin
         if (!cfg) ram_m[idx] = merge(ram_m[idx], wd, wen);
         else begin
            v = merge(cfg_read(off), wd, wen);
            if (off == 16'h0000) led_m = v[15:0];
            if (off == 16'h000C) scratch_m = v;
`ifdef CONFREG_TIMER_EN
            if (off == 16'h0004) begin
               base_val  = v;
               base_edge = cyc + 1;
            end
            if (off == 16'h0008) compare_m = v;
`endif
         end
      end
      @(negedge clk);
      check("led", {16'h0, led}, {16'h0, led_m});
      check("timer_int", {31'h0, timer_int}, {31'h0, int_m});
      if (!(en && wen == 4'h0)) check("rdata_hold", data_sram_rdata, rdata_m);
      data_sram_en = 1'b0;
   endtask

   // One cycle with rst=0; any access presented alongside it is dropped.
   task automatic drive_reset(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wd);
      rst = 1'b0;
      data_sram_en = en;
      data_sram_wen = wen;
      data_sram_addr = addr;
      data_sram_wdata = wd;
      led_m     = 16'h0;
      scratch_m = 32'h0;
      compare_m = 32'hFFFF_FFFF;
      int_m     = 1'b0;
      rdata_m   = 32'h0;
      base_val  = 32'h0;
      base_edge = cyc + 1;
      @(negedge clk);
      check("rst_rdata", data_sram_rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_timer_int", {31'h0, timer_int}, 32'h0);
      data_sram_en = 1'b0;
      rst = 1'b1;
   endtask

   function automatic logic [31:0] ram_addr(input logic [11:0] idx);
      logic [31:0] up;
      up = $urandom;
      if (up[31:16] == 16'hBFAF) up[31] = 1'b0;
      return {up[31:14], idx, up[1:0]};
   endfunction

   task automatic idle();
      drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b0;
      data_sram_en = 1'b0;
      data_sram_wen = 4'h0;
      data_sram_addr = 32'h0;
      data_sram_wdata = 32'h0;
      repeat (3) drive_reset(1'b0, 4'h0, 32'h0, 32'h0);

      // Reset values of the confreg window.
      drive(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);

      // RAM word write, back-to-back read, then byte-lane merge.
      drive(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678);
      drive(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      drive(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
      drive(1'b1, 4'h0, 32'h0000_0100, 32'h0);

      // Confreg map.
      drive(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_A5A5);
      drive(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_0010, 32'h1111_1111);
      drive(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_000C, 32'hDEAD_BEEF);
      drive(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);

      // Timer wrap and match, then clear by COMPARE write.
      drive(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
      drive(1'b1, 4'hF, 32'hBFAF_0008, 32'h0000_0001);
      repeat (6) idle();
      drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFF);
      repeat (2) idle();

      // TIMER write suppresses the increment; read returns the written value.
      drive(1'b1, 4'hF, 32'hBFAF_0004, 32'd100);
      drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      drive(1'b1, 4'b0011, 32'hBFAF_0004, 32'h0000_0200);
      drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);

      // Randomized mix over a preloaded RAM pool and the confreg window.
      pool[0] = 12'h040;
      for (int i = 1; i < 16; i++) pool[i] = 12'($urandom_range(0, 4095));
      for (int i = 1; i < 16; i++) drive(1'b1, 4'hF, ram_addr(pool[i]), $urandom);
      for (int n = 0; n < 400; n++) begin
         int          sel;
         logic [3:0]  w;
         sel = $urandom_range(0, 9);
         w   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         if (sel < 6)       drive(1'b1, w, ram_addr(pool[$urandom_range(0, 15)]), $urandom);
         else if (sel < 9)  drive(1'b1, w, {16'hBFAF, 11'h0, 3'($urandom_range(0, 7)), 2'($urandom)}, $urandom);
         else               idle();
      end

      // Reset mid-stream: dropped write and dropped read, RAM survives.
      drive(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_5A5A);
      drive(1'b1, 4'hF, 32'hBFAF_000C, 32'h0BAD_F00D);
      drive_reset(1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_CAFE);
      drive_reset(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      drive(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      repeat (3) idle();

      check("queue_drain", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
